// File: rtl/glasscell_pkg.sv
// Shared types for the fetch unit: word type, instruction size, FSM states, queue entry.
// Latency: n/a (types only).
// Backpressure: n/a (types only).
package glasscell_pkg;

  typedef logic [31:0] word_t;

  localparam int InstructionBytes = 4;

  typedef enum logic [1:0] {
    SYNC,
    RUN,
    DRAIN
  } fetch_state_t;

  typedef struct packed {
    word_t address;
    word_t instruction;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Synchronous FIFO of fetch_entry_t; head visible combinationally, clear empties it in one cycle.
// Latency: a pushed entry is visible at the head the cycle after the push.
// Backpressure: none internally; the caller must not push when full unless popping the same cycle.
// Ports: Clock/Reset (sync, active-high); clear; push + push_entry; pop; head; count; full; empty.
module fetch_queue
  import glasscell_pkg::*;
#(
  parameter int Depth = 2
) (
  input  logic                   Clock,
  input  logic                   Reset,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(Depth):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int PtrW = $clog2(Depth);
  localparam int CntW = PtrW + 1;

  fetch_entry_t    mem [Depth];
  logic [PtrW-1:0] rd_ptr;
  logic [PtrW-1:0] wr_ptr;

  always_ff @(posedge Clock) begin
    if (Reset || clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PtrW'(1);
      if (pop)  rd_ptr <= rd_ptr + PtrW'(1);
      count <= count + CntW'(push) - CntW'(pop);
    end
  end

  // Storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge Clock) begin
    if (push && !clear) mem[wr_ptr] <= push_entry;
  end

  assign head  = mem[rd_ptr];
  assign full  = (count == CntW'(Depth));
  assign empty = (count == '0);

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: reads r15, issues word reads to memory, queues returned words for decode.
// Latency: first instruction valid 1 cycle (SYNC) + 1 cycle (request) + memory latency after reset/redirect.
// Backpressure: requests only issue while a queue slot is free counting in-flight reads; memory responses are never stalled.
// Ports: Clock, Reset (sync, active-high); InstructionPointerIn, Flush, AdvanceOut to/from register bank;
//        MemRequest{Valid,Ready,Address}, MemResponse{Valid,Data} to memory;
//        Instruction{Valid,Ready,Out,AddressOut} to decode.
// Optional: FETCH_ALIGN_CHECK_EN adds FetchFault (sticky misaligned r15, cleared by Flush/Reset).
module fetch_unit
  import glasscell_pkg::*;
#(
  parameter int QueueDepth     = 2,
  parameter int MaxOutstanding = 2
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [31:0] InstructionPointerIn,
  input  logic        Flush,
  output logic        AdvanceOut,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        FetchFault,
`endif
  output logic        MemRequestValid,
  input  logic        MemRequestReady,
  output logic [31:0] MemRequestAddress,
  input  logic        MemResponseValid,
  input  logic [31:0] MemResponseData,
  output logic        InstructionValid,
  input  logic        InstructionReady,
  output logic [31:0] InstructionOut,
  output logic [31:0] InstructionAddressOut
);

  // Wide enough for in-flight + discarded responses plus one request in the flush cycle.
  localparam int CntW  = $clog2(MaxOutstanding + 2) + 1;
  localparam int QCntW = $clog2(QueueDepth) + 1;

  fetch_state_t    state, state_next;
  word_t           fetch_address;
  word_t           resp_address;   // address the next kept response belongs to
  logic [CntW-1:0] outstanding;
  logic [CntW-1:0] discard;
  logic [CntW-1:0] owed;
  logic [QCntW-1:0] q_count;
  logic            q_full, q_empty, q_push, q_pop;
  logic            req_fire, resp_live, fault;
  fetch_entry_t    q_head, q_entry;

`ifdef FETCH_ALIGN_CHECK_EN
  logic fetch_fault;

  always_ff @(posedge Clock) begin
    if (Reset || Flush) begin
      fetch_fault <= 1'b0;
    end else if (state == SYNC && InstructionPointerIn[1:0] != 2'b00) begin
      fetch_fault <= 1'b1;
    end
  end

  assign fault      = fetch_fault;
  assign FetchFault = fetch_fault;
`else
  assign fault = 1'b0;
`endif

  // A slot already promised to an in-flight read counts as occupied.
  always_comb begin
    MemRequestValid = 1'b0;
    if (state == RUN && !fault &&
        (32'(outstanding) + 32'(q_count) < 32'(QueueDepth)) &&
        (32'(outstanding) < 32'(MaxOutstanding))) begin
      MemRequestValid = 1'b1;
    end
  end

  assign req_fire  = MemRequestValid && MemRequestReady;
  assign resp_live = MemResponseValid && (discard == '0);

  assign q_pop   = InstructionValid && InstructionReady && !Flush;
  assign q_push  = resp_live && !Flush && (!q_full || q_pop);
  assign q_entry = '{address: resp_address, instruction: MemResponseData};

  // Every response still to come after this cycle; all of it is stale once Flush hits,
  // including a request that happens to be accepted in the flush cycle itself.
  assign owed = outstanding + discard + CntW'(req_fire) - CntW'(MemResponseValid);

  always_comb begin
    state_next = state;
    case (state)
      SYNC:    state_next = RUN;
      RUN:     state_next = RUN;
      DRAIN: begin
        if (discard == '0 || (discard == CntW'(1) && MemResponseValid)) state_next = SYNC;
      end
      default: state_next = SYNC;
    endcase
    if (Flush) state_next = (owed != '0) ? DRAIN : SYNC;
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state         <= SYNC;
      fetch_address <= '0;
      resp_address  <= '0;
      outstanding   <= '0;
      discard       <= '0;
    end else begin
      state <= state_next;

      if (state == SYNC) begin
        fetch_address <= InstructionPointerIn & ~32'h3;
        resp_address  <= InstructionPointerIn & ~32'h3;
      end else begin
        if (req_fire)  fetch_address <= fetch_address + 32'(InstructionBytes);
        if (resp_live) resp_address  <= resp_address + 32'(InstructionBytes);
      end

      if (Flush) begin
        outstanding <= '0;
        discard     <= owed;
      end else begin
        outstanding <= outstanding + CntW'(req_fire) - CntW'(resp_live);
        if (MemResponseValid && discard != '0) discard <= discard - CntW'(1);
      end
    end
  end

  fetch_queue #(
    .Depth (QueueDepth)
  ) u_queue (
    .Clock      (Clock),
    .Reset      (Reset),
    .clear      (Flush),
    .push       (q_push),
    .push_entry (q_entry),
    .pop        (q_pop),
    .head       (q_head),
    .count      (q_count),
    .full       (q_full),
    .empty      (q_empty)
  );

  assign MemRequestAddress     = fetch_address;
  assign InstructionValid      = !q_empty;
  assign InstructionOut        = q_empty ? 32'h0 : q_head.instruction;
  assign InstructionAddressOut = q_empty ? 32'h0 : q_head.address;
  assign AdvanceOut            = q_pop;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a small in-order memory model of selectable latency.
// Latency: n/a.
// Backpressure: drives MemRequestReady / InstructionReady from the stimulus.
module tb_fetch_unit;

  logic        Clock;
  logic        Reset;
  logic [31:0] InstructionPointerIn;
  logic        Flush;
  logic        AdvanceOut;
  logic        MemRequestValid;
  logic        MemRequestReady;
  logic [31:0] MemRequestAddress;
  logic        MemResponseValid;
  logic [31:0] MemResponseData;
  logic        InstructionValid;
  logic        InstructionReady;
  logic [31:0] InstructionOut;
  logic [31:0] InstructionAddressOut;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        FetchFault;
`endif

  fetch_unit #(
    .QueueDepth     (2),
    .MaxOutstanding (2)
  ) dut (
    .Clock                 (Clock),
    .Reset                 (Reset),
    .InstructionPointerIn  (InstructionPointerIn),
    .Flush                 (Flush),
    .AdvanceOut            (AdvanceOut),
`ifdef FETCH_ALIGN_CHECK_EN
    .FetchFault            (FetchFault),
`endif
    .MemRequestValid       (MemRequestValid),
    .MemRequestReady       (MemRequestReady),
    .MemRequestAddress     (MemRequestAddress),
    .MemResponseValid      (MemResponseValid),
    .MemResponseData       (MemResponseData),
    .InstructionValid      (InstructionValid),
    .InstructionReady      (InstructionReady),
    .InstructionOut        (InstructionOut),
    .InstructionAddressOut (InstructionAddressOut)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Memory: word at address A reads as A ^ 0xDEAD0000, returned lat_sel+1 cycles after acceptance.
  logic [3:0]  pipe_vld;
  logic [31:0] pipe_dat [4];
  logic [1:0]  lat_sel;

  always @(posedge Clock) begin
    if (Reset) begin
      pipe_vld <= '0;
    end else begin
      pipe_vld    <= {pipe_vld[2:0], MemRequestValid && MemRequestReady};
      pipe_dat[0] <= MemRequestAddress ^ 32'hDEAD_0000;
      for (int i = 1; i < 4; i++) pipe_dat[i] <= pipe_dat[i-1];
    end
  end

  assign MemResponseValid = pipe_vld[lat_sel];
  assign MemResponseData  = pipe_dat[lat_sel];

  int pass_cnt = 0;
  int total_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic cycle();
    @(posedge Clock);
    #1;
  endtask

  // Leaves the bench 1 time unit into the first cycle after Reset deasserts.
  task automatic do_reset(input logic [31:0] ip, input logic [1:0] lat, input logic irdy);
    Reset                = 1'b1;
    Flush                = 1'b0;
    InstructionPointerIn = ip;
    lat_sel              = lat;
    MemRequestReady      = 1'b1;
    InstructionReady     = irdy;
    repeat (2) @(posedge Clock);
    #1;
    Reset = 1'b0;
  endtask

  typedef struct {
    logic        mem_rdy;
    logic        ins_rdy;
    logic        mrv;
    logic [31:0] addr;
    logic        iv;
    logic [31:0] ins;
    logic [31:0] ia;
    logic        adv;
  } vec_t;

  vec_t vecs [12];
  int   fires;
  int   advs;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected bench completion");
    $fatal(1);
  end

  initial begin
    // Steady stream from 0x100, 1-cycle memory; cycle 0 is the SYNC cycle.
    vecs[0]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0000, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0100, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0104, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[3]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0108, 1'b1, 32'hDEAD_0100, 32'h0000_0100, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0108, 1'b1, 32'hDEAD_0104, 32'h0000_0104, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 32'h0000_010C, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 32'h0000_0110, 1'b1, 32'hDEAD_0108, 32'h0000_0108, 1'b1};
    vecs[7]  = '{1'b1, 1'b1, 1'b1, 32'h0000_0110, 1'b1, 32'hDEAD_010C, 32'h0000_010C, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 1'b1, 32'h0000_0114, 1'b0, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b0, 32'h0000_0118, 1'b1, 32'hDEAD_0110, 32'h0000_0110, 1'b0};
    vecs[10] = '{1'b1, 1'b1, 1'b0, 32'h0000_0118, 1'b1, 32'hDEAD_0110, 32'h0000_0110, 1'b1};
    vecs[11] = '{1'b1, 1'b1, 1'b1, 32'h0000_0118, 1'b1, 32'hDEAD_0114, 32'h0000_0114, 1'b1};

    // Table-driven stream
    do_reset(32'h0000_0100, 2'd0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      if (i > 0) cycle();
      MemRequestReady  = vecs[i].mem_rdy;
      InstructionReady = vecs[i].ins_rdy;
      #1;
      check($sformatf("stream[%0d] req_valid", i), 32'(MemRequestValid), 32'(vecs[i].mrv));
      check($sformatf("stream[%0d] req_addr", i), MemRequestAddress, vecs[i].addr);
      check($sformatf("stream[%0d] ins_valid", i), 32'(InstructionValid), 32'(vecs[i].iv));
      check($sformatf("stream[%0d] ins_out", i), InstructionOut, vecs[i].ins);
      check($sformatf("stream[%0d] ins_addr", i), InstructionAddressOut, vecs[i].ia);
      check($sformatf("stream[%0d] advance", i), 32'(AdvanceOut), 32'(vecs[i].adv));
    end

    // Decode stalled: only QueueDepth reads go out, nothing lost afterwards
    do_reset(32'h0000_0100, 2'd0, 1'b0);
    fires = 0;
    advs  = 0;
    for (int i = 0; i < 12; i++) begin
      if (i > 0) cycle();
      #1;
      if (MemRequestValid && MemRequestReady) fires++;
      if (AdvanceOut) advs++;
    end
    check("stall req_count", 32'(fires), 32'd2);
    check("stall advance_count", 32'(advs), 32'd0);
    check("stall req_valid", 32'(MemRequestValid), 32'd0);
    cycle();
    InstructionReady = 1'b1;
    #1;
    check("stall first ins", InstructionOut, 32'hDEAD_0100);
    check("stall first advance", 32'(AdvanceOut), 32'd1);
    cycle();
    #1;
    check("stall second ins", InstructionOut, 32'hDEAD_0104);
    check("stall second addr", InstructionAddressOut, 32'h0000_0104);
    check("stall second advance", 32'(AdvanceOut), 32'd1);

    // Memory not ready for 5 cycles: address held
    do_reset(32'h0000_0100, 2'd0, 1'b1);
    cycle();
    cycle();
    MemRequestReady = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) cycle();
      #1;
      check($sformatf("hold[%0d] req_valid", i), 32'(MemRequestValid), 32'd1);
      check($sformatf("hold[%0d] req_addr", i), MemRequestAddress, 32'h0000_0104);
    end
    cycle();
    MemRequestReady = 1'b1;
    #1;
    check("hold release addr", MemRequestAddress, 32'h0000_0104);
    cycle();
    #1;
    check("hold next addr", MemRequestAddress, 32'h0000_0108);
    cycle();
    #1;
    check("hold ins after release", InstructionOut, 32'hDEAD_0104);

    // Flush with two reads in flight (3-cycle memory)
    do_reset(32'h0000_0100, 2'd2, 1'b1);
    cycle();
    cycle();
    cycle();
    Flush                = 1'b1;
    InstructionPointerIn = 32'h0000_0200;
    #1;
    check("drain req_valid at flush", 32'(MemRequestValid), 32'd0);
    for (int c = 4; c <= 10; c++) begin
      cycle();
      Flush = 1'b0;
      #1;
      check($sformatf("drain[%0d] ins_valid", c), 32'(InstructionValid), 32'd0);
      if (c <= 6) check($sformatf("drain[%0d] req_valid", c), 32'(MemRequestValid), 32'd0);
      if (c == 7) begin
        check("drain restart req_valid", 32'(MemRequestValid), 32'd1);
        check("drain restart addr", MemRequestAddress, 32'h0000_0200);
      end
    end
    cycle();
    #1;
    check("drain first ins valid", 32'(InstructionValid), 32'd1);
    check("drain first ins", InstructionOut, 32'hDEAD_0200);
    check("drain first addr", InstructionAddressOut, 32'h0000_0200);

    // Flush in the same cycle as a pop
    do_reset(32'h0000_0100, 2'd0, 1'b1);
    cycle();
    cycle();
    cycle();
    Flush                = 1'b1;
    InstructionPointerIn = 32'h0000_0300;
    #1;
    check("flushpop ins_valid", 32'(InstructionValid), 32'd1);
    check("flushpop advance", 32'(AdvanceOut), 32'd0);
    cycle();
    Flush = 1'b0;
    #1;
    check("flushpop empty next", 32'(InstructionValid), 32'd0);
    check("flushpop sync req_valid", 32'(MemRequestValid), 32'd0);
    cycle();
    #1;
    check("flushpop restart addr", MemRequestAddress, 32'h0000_0300);
    check("flushpop restart req_valid", 32'(MemRequestValid), 32'd1);
    cycle();
    cycle();
    #1;
    check("flushpop first ins", InstructionOut, 32'hDEAD_0300);

`ifdef FETCH_ALIGN_CHECK_EN
    // Misaligned r15: sticky fault, no requests, cleared by Flush
    do_reset(32'h0000_0102, 2'd0, 1'b1);
    #1;
    check("align reset fault", 32'(FetchFault), 32'd0);
    for (int i = 1; i <= 3; i++) begin
      cycle();
      #1;
      check($sformatf("align[%0d] fault", i), 32'(FetchFault), 32'd1);
      check($sformatf("align[%0d] req_valid", i), 32'(MemRequestValid), 32'd0);
    end
    cycle();
    Flush                = 1'b1;
    InstructionPointerIn = 32'h0000_0104;
    cycle();
    Flush = 1'b0;
    #1;
    check("align cleared", 32'(FetchFault), 32'd0);
    cycle();
    #1;
    check("align resume req_valid", 32'(MemRequestValid), 32'd1);
    check("align resume addr", MemRequestAddress, 32'h0000_0104);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
